// File: rtl/spi_adc_scanner.sv
// spi_adc_scanner: SPI master for an MCP320x-style multi-channel ADC.
// Produces registered parallel samples tagged with their channel, supports
// single-shot and continuous masked-scan operation, and keeps a per-channel
// "sample >= thresh" flag vector.
module spi_adc_scanner #(
    parameter int DATA_W  = 12,
    parameter int N_CH    = 4,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [$clog2(N_CH)-1:0] ch_sel,
    input  logic                    scan_en,
    input  logic [N_CH-1:0]         ch_mask,
    input  logic [DATA_W-1:0]       thresh,
    input  logic                    miso,
    output logic                    mosi,
    output logic                    sck,
    output logic                    cs_n,
    output logic [DATA_W-1:0]       data,
    output logic [$clog2(N_CH)-1:0] data_ch,
    output logic                    valid,
    output logic                    busy,
    output logic [N_CH-1:0]         above
);

    localparam int CH_W       = $clog2(N_CH);
    localparam int FRAME      = 3 + CH_W + DATA_W;
    localparam int FIRST_DATA = FRAME - DATA_W;
    localparam int BIT_W      = $clog2(FRAME);
    localparam int CMD_W      = 1 + CH_W;
    localparam int CNT_MAX    = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam int unsigned     NCH_U     = N_CH;
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME - 1);
    localparam logic [BIT_W-1:0] DATA_PREV = BIT_W'(FIRST_DATA - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [BIT_W-1:0]    bit_idx, bit_d;
    logic [DATA_W-1:0]   shreg, shreg_d;
    logic [CMD_W-1:0]    cmd_sr, cmd_sr_d;
    logic [CH_W-1:0]     ch_cur, ch_cur_d;
    logic [CH_W-1:0]     scan_ptr, scan_ptr_d;
    logic                sck_d, cs_n_d, mosi_d, busy_d, valid_d;
    logic [DATA_W-1:0]   data_d;
    logic [CH_W-1:0]     data_ch_d;
    logic [N_CH-1:0]     above_d;
    logic [CH_W-1:0]     scan_ch, cand;
    logic                scan_hit;

    // Next enabled channel, searching upward from one past the scan pointer.
    // "No channel converted yet" is encoded as pointer = N_CH-1, so the first
    // search starts at channel 0 and yields the lowest enabled channel.
    always_comb begin
        scan_ch  = '0;
        scan_hit = 1'b0;
        cand     = scan_ptr;
        for (int unsigned i = 0; i < NCH_U; i++) begin
            cand = (cand == CH_LAST) ? '0 : cand + CH_W'(1);
            if (!scan_hit && ch_mask[cand]) begin
                scan_hit = 1'b1;
                scan_ch  = cand;
            end
        end
    end

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        bit_d      = bit_idx;
        shreg_d    = shreg;
        cmd_sr_d   = cmd_sr;
        ch_cur_d   = ch_cur;
        scan_ptr_d = scan_ptr;
        sck_d      = sck;
        cs_n_d     = cs_n;
        mosi_d     = mosi;
        busy_d     = busy;
        valid_d    = 1'b0;
        data_d     = data;
        data_ch_d  = data_ch;
        above_d    = above;
        case (state)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if ((start && !scan_en) || (scan_en && scan_hit)) begin
                    state_d  = SETUP;
                    ch_cur_d = scan_en ? scan_ch : ch_sel;
                    cmd_sr_d = {1'b1, (scan_en ? scan_ch : ch_sel)};
                    cs_n_d   = 1'b0;
                    mosi_d   = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == DIV_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sck_d   = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt != DIV_LAST) begin
                    cnt_d = cnt + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (sck) begin
                        // Falling edge: present the next command bit.
                        sck_d    = 1'b0;
                        mosi_d   = cmd_sr[CMD_W-1];
                        cmd_sr_d = {cmd_sr[CMD_W-2:0], 1'b0};
                    end else if (bit_idx == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        // Rising edge: sample miso for data periods only.
                        sck_d = 1'b1;
                        bit_d = bit_idx + BIT_W'(1);
                        if (bit_idx >= DATA_PREV) begin
                            shreg_d = {shreg[DATA_W-2:0], miso};
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt == DIV_LAST) begin
                    state_d          = GAP;
                    cnt_d            = '0;
                    cs_n_d           = 1'b1;
                    mosi_d           = 1'b0;
                    valid_d          = 1'b1;
                    data_d           = shreg;
                    data_ch_d        = ch_cur;
                    scan_ptr_d       = ch_cur;
                    above_d[ch_cur]  = (shreg >= thresh);
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            cmd_sr   <= '0;
            ch_cur   <= '0;
            scan_ptr <= CH_LAST;
            sck      <= 1'b0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            data     <= '0;
            data_ch  <= '0;
            above    <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bit_idx  <= bit_d;
            shreg    <= shreg_d;
            cmd_sr   <= cmd_sr_d;
            ch_cur   <= ch_cur_d;
            scan_ptr <= scan_ptr_d;
            sck      <= sck_d;
            cs_n     <= cs_n_d;
            mosi     <= mosi_d;
            busy     <= busy_d;
            valid    <= valid_d;
            data     <= data_d;
            data_ch  <= data_ch_d;
            above    <= above_d;
        end
    end

endmodule
